// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; the master modport is the view
// of everything around it (both requesters plus the memory read port).
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single synchronous on-chip memory.
// Zero-latency round-robin grant, one access per cycle, with a bounded
// bus lock so a requester can do read-modify-write without interleaving.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} st_t;

  st_t           st;
  st_t           st_nxt;
  logic          last;
  logic          last_nxt;
  logic [7:0]    hold;
  logic [7:0]    hold_nxt;
  logic [1:0]    rv_p1;
  logic [1:0]    rv_nxt;
  logic          gnt0;
  logic          gnt1;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          we_sel;

  // Grant decision: round-robin in IDLE, owner-only while locked, none in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (Resetn) begin
      case (st)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = last;
            gnt1 = ~last;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
        LOCK0:   gnt0 = bus.req0;
        LOCK1:   gnt1 = bus.req1;
        default: ;
      endcase
    end
  end

  // Memory mux: granted requester drives the memory; requester 0 parks on it otherwise
  always_comb begin
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    we_sel    = 1'b0;
    if (gnt1) begin
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
      we_sel    = bus.we1;
    end else if (gnt0) begin
      we_sel    = bus.we0;
    end
    if (!Resetn) begin
      addr_sel  = '0;
      wdata_sel = '0;
      we_sel    = 1'b0;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = we_sel;
  assign bus.rvalid0   = rv_p1[0];
  assign bus.rvalid1   = rv_p1[1];
  assign bus.rdata     = bus.mem_rdata;

  // Next state: fairness pointer, lock entry/exit with tenure limit, read-valid pipeline
  always_comb begin
    st_nxt   = st;
    last_nxt = last;
    hold_nxt = hold;
    rv_nxt   = {gnt1 & ~bus.we1, gnt0 & ~bus.we0};
    if (gnt0) last_nxt = 1'b0;
    if (gnt1) last_nxt = 1'b1;
    case (st)
      IDLE: begin
        if (gnt0 && bus.lock0) begin
          st_nxt   = LOCK0;
          hold_nxt = 8'd1;
        end else if (gnt1 && bus.lock1) begin
          st_nxt   = LOCK1;
          hold_nxt = 8'd1;
        end
      end
      LOCK0: begin
        if (!bus.lock0) begin
          st_nxt   = IDLE;
          hold_nxt = 8'd0;
        end else if (hold == 8'(MAX_LOCK)) begin
          // forced release: pointer left on 0 so requester 1 wins the next tie
          st_nxt   = IDLE;
          last_nxt = 1'b0;
          hold_nxt = 8'd0;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      LOCK1: begin
        if (!bus.lock1) begin
          st_nxt   = IDLE;
          hold_nxt = 8'd0;
        end else if (hold == 8'(MAX_LOCK)) begin
          st_nxt   = IDLE;
          last_nxt = 1'b1;
          hold_nxt = 8'd0;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      default: begin
        st_nxt   = IDLE;
        hold_nxt = 8'd0;
      end
    endcase
  end

  // State register; reset aborts any in-flight read and drops the lock
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st    <= IDLE;
      last  <= 1'b1;
      hold  <= 8'd0;
      rv_p1 <= 2'b00;
    end else begin
      st    <= st_nxt;
      last  <= last_nxt;
      hold  <= hold_nxt;
      rv_p1 <= rv_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ML = 4;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // synchronous memory behind the arbiter
  logic [DW-1:0] mem [256];
  always @(posedge Clock) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: who owns the bus, how long it has owned it, who went last
  int            owner;
  int            lcyc;
  bit            last_srv;
  bit            pend0, pend1;
  bit            pdata_ok;
  logic [DW-1:0] pdata;
  bit            eg0, eg1;
  logic [DW-1:0] shadow [int];

  task automatic model_reset();
    owner    = -1;
    lcyc     = 0;
    last_srv = 1'b1;
    pend0    = 1'b0;
    pend1    = 1'b0;
    pdata_ok = 1'b0;
  endtask

  task automatic model_step();
    bit            g0, g1, ew, own_lock;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    g0 = 1'b0;
    g1 = 1'b0;
    if (Resetn) begin
      if (owner == 0)      g0 = bus.req0;
      else if (owner == 1) g1 = bus.req1;
      else if (bus.req0 && bus.req1) begin
        g0 = (last_srv == 1'b1);
        g1 = !g0;
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
    end
    if (!Resetn)  begin ea = '0;        ed = '0;         ew = 1'b0;    end
    else if (g0)  begin ea = bus.addr0; ed = bus.wdata0; ew = bus.we0; end
    else if (g1)  begin ea = bus.addr1; ed = bus.wdata1; ew = bus.we1; end
    else          begin ea = bus.addr0; ed = bus.wdata0; ew = 1'b0;    end

    chk("gnt0",      32'(bus.gnt0),      32'(g0));
    chk("gnt1",      32'(bus.gnt1),      32'(g1));
    chk("mem_we",    32'(bus.mem_we),    32'(ew));
    chk("mem_addr",  32'(bus.mem_addr),  32'(ea));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    chk("rvalid0",   32'(bus.rvalid0),   32'(Resetn && pend0));
    chk("rvalid1",   32'(bus.rvalid1),   32'(Resetn && pend1));
    if (Resetn && (pend0 || pend1) && pdata_ok)
      chk("rdata", 32'(bus.rdata), 32'(pdata));

    if (!Resetn) begin
      model_reset();
    end else begin
      pend0    = g0 && !bus.we0;
      pend1    = g1 && !bus.we1;
      pdata_ok = 1'b0;
      if (pend0 && shadow.exists(int'(bus.addr0))) begin
        pdata_ok = 1'b1;
        pdata    = shadow[int'(bus.addr0)];
      end
      if (pend1 && shadow.exists(int'(bus.addr1))) begin
        pdata_ok = 1'b1;
        pdata    = shadow[int'(bus.addr1)];
      end
      if (g0 && bus.we0) shadow[int'(bus.addr0)] = bus.wdata0;
      if (g1 && bus.we1) shadow[int'(bus.addr1)] = bus.wdata1;
      if (g0) last_srv = 1'b0;
      if (g1) last_srv = 1'b1;
      if (owner >= 0) begin
        lcyc++;
        own_lock = (owner == 0) ? bus.lock0 : bus.lock1;
        if (!own_lock) owner = -1;
        else if (lcyc == ML) begin
          last_srv = (owner == 1);
          owner    = -1;
        end
      end else if (g0 && bus.lock0) begin
        owner = 0;
        lcyc  = 0;
      end else if (g1 && bus.lock1) begin
        owner = 1;
        lcyc  = 0;
      end
    end
    eg0 = g0;
    eg1 = g1;
  endtask

  // one cycle: check at the falling edge, then advance past the rising edge
  task automatic step();
    @(negedge Clock);
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic rand0();
    bus.req0   = ($urandom_range(0, 99) < 60);
    bus.we0    = 1'($urandom_range(0, 1));
    bus.lock0  = ($urandom_range(0, 99) < 30);
    bus.addr0  = AW'($urandom_range(0, 15));
    bus.wdata0 = DW'($urandom);
  endtask

  task automatic rand1();
    bus.req1   = ($urandom_range(0, 99) < 60);
    bus.we1    = 1'($urandom_range(0, 1));
    bus.lock1  = ($urandom_range(0, 99) < 30);
    bus.addr1  = AW'($urandom_range(0, 15));
    bus.wdata1 = DW'($urandom);
  endtask

  initial begin
    model_reset();
    idle_inputs();
    Resetn = 1'b0;
    step();
    step();
    Resetn = 1'b1;

    // write then read back through the other requester
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 16'h00AA;
    step();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
    step();
    bus.req1 = 1'b0;
    step();

    // six-cycle tie of reads: alternation 0,1,0,1,0,1
    bus.req0 = 1'b1; bus.addr0 = 8'h10;
    bus.req1 = 1'b1; bus.addr1 = 8'h11;
    for (int i = 0; i < 6; i++) step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();

    // idle bus
    for (int i = 0; i < 10; i++) step();

    // read-modify-write under lock while requester 1 waits
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b1; bus.addr0 = 8'h20;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
    step();
    bus.we0 = 1'b1; bus.lock0 = 1'b0; bus.wdata0 = 16'h1234;
    step();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    step();
    bus.req1 = 1'b0;
    step();

    // lock timeout: requester 0 keeps its lock, requester 1 keeps asking
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b1; bus.addr0 = 8'h20;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
    for (int i = 0; i < 12; i++) step();
    idle_inputs();
    step();
    step();

    // reset in the cycle after a read grant
    bus.req0 = 1'b1; bus.addr0 = 8'h10;
    step();
    bus.req0 = 1'b0;
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    idle_inputs();
    step();

    // randomized traffic obeying the hold-until-granted handshake
    rand0();
    rand1();
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) begin
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
      end else begin
        step();
      end
      if (!bus.req0 || eg0) rand0();
      if (!bus.req1 || eg1) rand1();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the processor system's single synchronous on-chip memory between two bus masters: the processor (requester 0) and an I/O copy engine (requester 1) that mirrors switch values into memory and memory words out to the LED/HEX registers. It grants one access per cycle with round-robin fairness and supports a bounded bus lock for read-modify-write sequences. It sits between both masters and the memory inside the top-level system, clocked by the board clock.

## Interface
- AW, 8: memory address width (256 words)
- DW, 16: data word width
- MAX_LOCK, 8: maximum cycles a lock may hold the bus; legal range 1..255
- Clock  in  1  system clock; all state changes on the rising edge
- Resetn  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  access request; held until granted
- we0, we1  in  1 each  1 = write, 0 = read
- lock0, lock1  in  1 each  request to keep ownership after this grant
- addr0, addr1  in  AW each  word address
- wdata0, wdata1  in  DW each  write data
- gnt0, gnt1  out  1 each  access accepted at the end of this cycle
- rvalid0, rvalid1  out  1 each  read data valid on rdata this cycle
- rdata  out  DW  read data, common to both requesters
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data, valid one cycle after the address edge

## Operation
- State: `last` is the last-served requester (1 bit). `st` is IDLE, LOCK0 or LOCK1. `hold` is an 8-bit lock-cycle counter. `rv` is a 2-bit read-valid pipeline.
- Reset values: st=IDLE, last=1 (requester 0 wins the first tie), hold=0, rv=0. While Resetn=0: gnt0=gnt1=0, rvalid0=rvalid1=0, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE grant is combinational:
  - Only one reqN high: grant N.
  - Both high: grant the requester other than `last`.
- LOCKn: only requester n can be granted. The other requester's req is ignored and it waits with no grant.
- Memory mux:
  - When gntN=1: mem_addr/mem_wdata = addrN/wdataN and mem_we = weN.
  - With no grant: mem_we=0 and mem_addr/mem_wdata carry requester 0's values.
- Update on each grant to N: last <= N. If weN=0, rv[N] <= 1 for the next cycle; otherwise rv <= 0.
- Read return: rvalidN = rv[N]; rdata = mem_rdata, passed through combinationally.
- Lock entry: granted in IDLE with lockN=1 -> st <= LOCKN, hold <= 1.
- Lock exit, evaluated every cycle in LOCKn:
  - lockn=0 -> st <= IDLE. A transaction granted in that same cycle still completes.
  - Otherwise, hold == MAX_LOCK -> forced st <= IDLE and last <= n, so the other requester gets the next tie.
  - Otherwise hold <= hold+1. This applies to every LOCKn cycle, with or without a request.
- Asserting lock while not granted has no effect.
- Resetn low mid-transaction aborts it: no rvalid is produced and the lock is dropped.

## Timing
- Grant latency: 0 cycles. gntN is asserted in the same cycle reqN is seen, if the bus is free.
- Handshake: a requester changes addr/we/wdata/req only after the cycle in which its gnt=1. A requester that keeps req high after a grant requests a new access, which is arbitrated again.
- Read latency: 1 cycle. A grant in cycle t gives rvalidN=1 with rdata valid in cycle t+1.
- Back-to-back accesses: one grant per cycle, so throughput is 1 access/cycle.
- Simultaneous requests in IDLE alternate: 0,1,0,1...
- A forced lock release takes effect in the cycle after hold reaches MAX_LOCK. The maximum lock tenure is MAX_LOCK cycles.
- Worst-case wait for a requester is MAX_LOCK+1 cycles.

## Test plan
- Reset, then req0=1, we0=1, addr0=8'h10, wdata0=16'h00AA -> gnt0 in the same cycle, mem_we=1, mem_addr=8'h10, no rvalid. Then a read of 8'h10 by req1 -> gnt1, and next cycle rvalid1=1, rdata=16'h00AA, rvalid0=0.
- req0 and req1 held high for 6 cycles (all reads) -> grant order 0,1,0,1,0,1, with one rvalid per grant one cycle later to the matching requester.
- Read-modify-write: req0 read with lock0=1, then write with lock0=0, while req1 is held high -> gnt1 stays low until the cycle after the lock0=0 grant, then gnt1=1.
- Lock timeout with MAX_LOCK=4: lock0 held high and req1 high -> requester 1 granted within 5 cycles of lock entry, and the next tie after that goes to requester 1.
- Resetn pulsed low in the cycle after a read grant -> rvalid stays 0, st returns to IDLE, and the next simultaneous request is granted to requester 0.
- Idle bus: req0=req1=0 for 10 cycles -> mem_we=0, gnt0=gnt1=0, rvalid0=rvalid1=0 throughout.
